// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared receive-path encodings for rate, depuncturer state and puncture periods
package rx_pkg;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S_A  = 2'd1,
        S_B  = 2'd2
    } state_t;

    localparam int unsigned PERIOD_1_2 = 1;
    localparam int unsigned PERIOD_2_3 = 2;
    localparam int unsigned PERIOD_3_4 = 3;

endpackage

// File: rtl/puncture_pattern.sv
// rtl/puncture_pattern.sv - stolen-bit positions and period end for a given rate and phase
module puncture_pattern
    import rx_pkg::*;
(
    input  rate_t      rate,
    input  logic [1:0] phase,
    output logic       erase_a,
    output logic       erase_b,
    output logic       phase_last
);

    // Reserved rate falls through to the rate-1/2 pattern.
    always_comb begin
        erase_a    = 1'b0;
        erase_b    = 1'b0;
        phase_last = 1'b1;
        case (rate)
            RATE_2_3: begin
                erase_b    = (phase == 2'd1);
                phase_last = (phase == 2'(PERIOD_2_3 - 1));
            end
            RATE_3_4: begin
                erase_b    = (phase == 2'd1);
                erase_a    = (phase == 2'd2);
                phase_last = (phase == 2'(PERIOD_3_4 - 1));
            end
            default: phase_last = (phase == 2'(PERIOD_1_2 - 1));
        endcase
    end

endmodule

// File: rtl/viterbi_depuncturer.sv
// rtl/viterbi_depuncturer.sv - re-inserts stolen bits as erasures and emits rate-1/2 (A,B) pairs
module viterbi_depuncturer
    import rx_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [1:0]           Rate,
    input  logic [LEN_WIDTH-1:0] Length,
    input  logic                 In_Bit,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    output logic                 Out_A,
    output logic                 Out_B,
    output logic                 Out_EraseA,
    output logic                 Out_EraseB,
    output logic                 Out_Last,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic                 Busy
);

    state_t               state, state_nxt;
    rate_t                rate_q;
    logic [LEN_WIDTH-1:0] len_q, count;
    logic [1:0]           phase;
    logic                 a_q, ea_q;
    logic                 erase_a, erase_b, phase_last;
    logic                 out_free, start_ok, pair_last;
    logic                 done_a, done_b;

    puncture_pattern u_pattern (
        .rate       (rate_q),
        .phase      (phase),
        .erase_a    (erase_a),
        .erase_b    (erase_b),
        .phase_last (phase_last)
    );

    assign out_free  = !Out_Valid || Out_Ready;
    assign start_ok  = Start && (Length != '0);
    assign pair_last = (count == len_q - LEN_WIDTH'(1));
    assign Busy      = (state != IDLE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Both positions wait for a free output register so a completing B never overwrites a stalled pair.
    always_comb begin
        state_nxt = state;
        In_Ready  = 1'b0;
        done_a    = 1'b0;
        done_b    = 1'b0;
        case (state)
            S_A: begin
                if (erase_a) begin
                    done_a = !start_ok;
                end else begin
                    In_Ready = out_free && !start_ok;
                    done_a   = In_Ready && In_Valid;
                end
            end
            S_B: begin
                if (erase_b) begin
                    done_b = out_free && !start_ok;
                end else begin
                    In_Ready = out_free && !start_ok;
                    done_b   = In_Ready && In_Valid;
                end
            end
            default: ;
        endcase
        if (done_a) state_nxt = S_B;
        if (done_b) state_nxt = pair_last ? IDLE : S_A;
        if (start_ok) state_nxt = S_A;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rate_q     <= RATE_1_2;
            len_q      <= '0;
            count      <= '0;
            phase      <= 2'd0;
            a_q        <= 1'b0;
            ea_q       <= 1'b0;
            Out_A      <= 1'b0;
            Out_B      <= 1'b0;
            Out_EraseA <= 1'b0;
            Out_EraseB <= 1'b0;
            Out_Last   <= 1'b0;
            Out_Valid  <= 1'b0;
        end else if (start_ok) begin
            rate_q <= rate_t'(Rate);
            len_q  <= Length;
            count  <= '0;
            phase  <= 2'd0;
            // An abort drops the pending pair; a pair left over from a finished frame still drains.
            if (state != IDLE || Out_Ready) Out_Valid <= 1'b0;
        end else begin
            if (done_a) begin
                a_q  <= erase_a ? 1'b0 : In_Bit;
                ea_q <= erase_a;
            end
            if (done_b) begin
                Out_A      <= a_q;
                Out_EraseA <= ea_q;
                Out_B      <= erase_b ? 1'b0 : In_Bit;
                Out_EraseB <= erase_b;
                Out_Last   <= pair_last;
                Out_Valid  <= 1'b1;
                count      <= count + LEN_WIDTH'(1);
                phase      <= phase_last ? 2'd0 : phase + 2'd1;
            end else if (Out_Ready) begin
                Out_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/viterbi_depuncturer.md
Name: viterbi_depuncturer

Overview:
- Sits between the deinterleaver/demapper and the Viterbi decoder in the 802.11a receiver.
- Takes the serial punctured coded-bit stream and re-inserts the stolen bits as erasures for rate 2/3 and 3/4.
- Emits one rate-1/2 (A,B) pair per handshake, with per-bit erase flags; the decoder uses these to zero the branch cost of erased bits.
- Frame length (in pairs) and rate are latched on a Start pulse.

Parameters:
- LEN_WIDTH, 16, width of the frame length in output pairs (covers the maximum PSDU plus tail and pad).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that latches Rate and Length and begins a frame.
- Rate  input  2  00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = reserved (treated as 1/2).
- Length  input  LEN_WIDTH  number of output pairs in the frame.
- In_Bit  input  1  coded bit from the deinterleaver.
- In_Valid  input  1  In_Bit is valid.
- In_Ready  output  1  block accepts In_Bit this cycle.
- Out_A  output  1  first coded bit of the pair (0 when erased).
- Out_B  output  1  second coded bit of the pair (0 when erased).
- Out_EraseA  output  1  Out_A is a stolen position.
- Out_EraseB  output  1  Out_B is a stolen position.
- Out_Last  output  1  current pair is the final pair of the frame.
- Out_Valid  output  1  the pair outputs are valid.
- Out_Ready  input  1  downstream accepts the pair.
- Busy  output  1  high while not in IDLE.

Behaviour:
- Reset (async, low): state = IDLE; phase = 0; pair counter = 0. All outputs are 0, including In_Ready, Out_Valid and Busy.
- Puncture pattern, indexed by phase:
  - 1/2: period 1. A and B are both received.
  - 2/3: period 2. Phase 0: A,B received. Phase 1: A received, B erased.
  - 3/4: period 3. Phase 0: A,B received. Phase 1: A received, B erased. Phase 2: A erased, B received.
- States: IDLE, S_A, S_B.
- IDLE:
  - Start with Length != 0 → latch Rate and Length, phase = 0, count = 0, go to S_A next cycle.
  - Start with Length = 0 is ignored.
- S_A:
  - Position received: In_Ready = 1 only if the output register is free or being drained this cycle. On In_Valid && In_Ready, capture A and go to S_B.
  - Position erased: A = 0, EraseA = 1, go to S_B after one cycle with no input consumed.
- S_B:
  - Same rule for B; the input is gated by the same output-free condition.
  - On completion, load the pair into the output register (Out_Valid = 1 next cycle) and increment the count.
  - Out_Last = 1 when count == Length-1.
  - Advance phase modulo the period. Go to S_A, or to IDLE if this pair was the last.
- Output register holds its value while Out_Valid && !Out_Ready. Out_Valid drops after the handshake unless a new pair loads in the same cycle.
- Throughput: one input bit per cycle; one cycle per erased position. Latency from accepting the B bit to Out_Valid is 1 cycle.
- Phase wraps at the period. A frame may end mid-period; the remaining pattern is discarded.
- Start while Busy aborts the current frame:
  - The pending output pair is dropped and Out_Valid is cleared.
  - The new Rate and Length are latched and phase restarts at 0.
- Start and a completing handshake in the same cycle: Start wins.
- Rate and Length are ignored except on Start.
- In_Valid is ignored in IDLE and in erased positions.
- Async reset mid-frame returns all state to reset values immediately.

Decomposition:
- Shared package rx_pkg holds:
  - RATE_1_2 / RATE_2_3 / RATE_3_4 encodings.
  - State encodings IDLE, S_A, S_B.
  - Period constants 1/2/3.
- One combinational sub-module, puncture_pattern: (rate, phase) → erase_a, erase_b, phase_last. It is reused by the transmit-side puncturer.

Test Plan:
- Rate 1/2, Length 3, In_Bit 1,0,1,1,0,0 with Out_Ready = 1:
  - Expected pairs (1,0) (1,1) (0,0), no erase flags.
  - Out_Last on the 3rd pair; Busy then falls.
- Rate 2/3, Length 4, In_Bit 1,1,0,0,1,0:
  - Expected pairs (1,1) (0,E) (0,1) (0,E), where E = bit 0 with its erase flag set.
  - Exactly 6 bits consumed.
- Rate 3/4, Length 6, In_Bit 1,0,1,1,0,1,0,0:
  - Expected pairs (1,0) (1,E) (E,1) (0,1) (0,E) (E,0).
  - Exactly 8 bits consumed; Out_Last on the 6th pair.
- 3/4 frame with Out_Ready held low for 5 cycles after the first pair:
  - The pair stays stable and In_Ready = 0 at each pair completion.
  - No bit is lost or duplicated; the sequence matches the previous case.
- Start during the 3rd pair of a 3/4 frame, new Rate 1/2, Length 2:
  - The pending pair is dropped; the next pairs follow the 1/2 pattern from phase 0.
  - Out_Last on the 2nd pair.
- Reset pulsed low mid-frame:
  - All outputs are 0 within the same cycle.
  - Start with Rate 11 and Length 1 then yields one unerased pair.
